// File: rtl/ifetch_queue.sv
// ifetch_queue: holds the fetch PC, reads a combinational instruction memory,
// and buffers {instruction, PC} pairs in a small FIFO. Decode takes entries
// over a valid/ready handshake. A redirect flushes the FIFO and restarts
// fetch at a new target.
module ifetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [WIDTH-3:0]         imem_add,
  input  logic [WIDTH-1:0]         imem_data,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [WIDTH-1:0]         inst,
  output logic [WIDTH-1:0]         inst_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [WIDTH-3:0] WORD_ONE = (WIDTH-2)'(1);

  logic [WIDTH-3:0] fetch_word;
  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-3:0] word_mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;

  logic push;
  logic pop;

  // Handshake decode. A redirect suppresses both sides in the same cycle so
  // decode never consumes an instruction from the path being discarded.
  always_comb begin
    push       = !redirect && (cnt != CNT_FULL);
    inst_valid = (cnt != '0) && !redirect;
    pop        = inst_valid && inst_ready;
  end

  // Outputs come straight from the fetch register and the head entry; when
  // empty the head shows stale or cleared data while inst_valid is low.
  always_comb begin
    imem_add = fetch_word;
    inst     = inst_mem[rd_ptr];
    inst_pc  = {word_mem[rd_ptr], 2'b00};
    count    = cnt;
  end

  // Fetch PC, pointers, occupancy and entry storage. A full queue blocks the
  // push even when the head is popped that cycle, costing one refill bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_word <= RESET_PC[WIDTH-1:2];
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        word_mem[i] <= '0;
      end
    end else if (redirect) begin
      fetch_word <= redirect_pc[WIDTH-1:2];
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= imem_data;
        word_mem[wr_ptr] <= fetch_word;
        wr_ptr           <= wr_ptr + PTR_ONE;
        fetch_word       <= fetch_word + WORD_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch unit that initiates reads from the instruction memory.
- Holds the fetch PC and drives the word-aligned address to the instruction memory, which returns data combinationally in the same cycle.
- Captures the returned instruction words, with their PCs, into a small FIFO.
- Hands instructions to decode over a valid/ready handshake; a redirect input (branch/jump) flushes the queue and restarts fetch.

Parameters:
- WIDTH, 32: data and byte-address width.
- DEPTH, 4: number of queue entries; must be a power of 2, minimum 2.
- RESET_PC, 0: byte address of the first fetch after reset; bits [1:0] ignored.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_add  out  WIDTH-2  word address to instruction memory (byte address >> 2).
- imem_data  in  WIDTH  instruction word from memory, valid in the same cycle as imem_add.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  WIDTH  byte target address; bits [1:0] ignored.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst  out  WIDTH  instruction at the queue head.
- inst_pc  out  WIDTH  byte PC of inst; bits [1:0] always 0.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- State:
  - fetch_word (WIDTH-2 bits).
  - Entry storage: instruction plus word PC per entry.
  - Read pointer, write pointer, count.
- Reset (rst=1 at posedge):
  - fetch_word <= RESET_PC[WIDTH-1:2].
  - Pointers and count <= 0; storage cleared.
  - Hence inst_valid=0, inst=0, inst_pc=0, count=0.
  - Reset mid-operation discards all queued entries, and any redirect asserted in the same cycle is ignored.
- Address output:
  - imem_add = fetch_word, combinational from the register, every cycle including while full.
- Push:
  - push = !redirect && (count != DEPTH).
  - On push: write {imem_data, fetch_word} at the write pointer, advance the write pointer, and fetch_word <= fetch_word + 1.
- Wrap-around:
  - fetch_word wraps modulo 2^(WIDTH-2); all-ones + 1 gives 0.
  - The pushed PC of the last word is (2^(WIDTH-2) - 1) << 2.
- Pop:
  - inst_valid = (count != 0) && !redirect. The combinational gating by redirect is intentional.
  - pop = inst_valid && inst_ready; advance the read pointer on pop.
- inst and inst_pc:
  - Driven from the head entry: inst_pc = {head_word, 2'b00}.
  - Undefined content is never exposed; when empty the head shows stale or reset data with inst_valid=0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- Full: count==DEPTH.
  - No push and fetch_word holds.
  - A pop in the same cycle does not allow a push; the push resumes the next cycle, a one-bubble refill penalty that is accepted.
- Empty: inst_valid=0; a push this cycle makes inst_valid=1 next cycle. There is no same-cycle bypass.
- Redirect (highest priority after rst):
  - Pointers and count <= 0.
  - fetch_word <= redirect_pc[WIDTH-1:2].
  - No push and no pop that cycle.
- Latency:
  - Fetch to inst_valid: 1 cycle.
  - Redirect asserted at cycle N: target fetched at N+1, inst_valid with inst_pc = target at N+2.
- Pointer wrap: read and write pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset release, RESET_PC=0, inst_ready=1, memory word k = 0x1000+k -> inst_valid rises the cycle after reset. Each cycle thereafter inst/inst_pc = (0x1000,0x0), (0x1001,0x4), (0x1002,0x8)… with count stable at 1.
- inst_ready=0 for 8 cycles after reset -> count reaches 4 (DEPTH) after 4 cycles, imem_add holds at 4, no entry is overwritten. Then ready=1 drains 0x1000..0x1003 in order, followed by 0x1004 after the one-bubble refill.
- Streaming at pc 0x10, redirect=1 with redirect_pc=0x203 -> inst_valid=0 in the redirect cycle, count=0 next cycle, imem_add=0x80. The first valid output after that has inst_pc=0x200 at N+2.
- Count=2 with push and pop in the same cycle -> count stays 2 and order is preserved. With count=DEPTH and pop -> count drops to 3 and imem_add is unchanged that cycle.
- redirect_pc=0xFFFFFFFC, ready=1 -> entries with inst_pc 0xFFFFFFFC, then 0x00000000, then 0x00000004, with imem_add wrapping to 0.
- Queue full with redirect and rst both asserted -> after the edge, state equals reset state: imem_add = RESET_PC>>2, count=0, inst=0, inst_pc=0.
